// File: rtl/h14tx_period_sched.sv
// rtl/h14tx_period_sched.sv - HDMI 1.4 period scheduler: lookahead delay line, video preamble/guard, data-island insertion
// Optional protocol checker on err is built only when H14TX_SCHED_CHECK_EN is defined.
package h14tx_pkg;
    typedef logic [23:0] video_t;
    typedef logic [2:0]  period_t;
    typedef logic [1:0]  ctl_t;

    localparam period_t P_CONTROL     = 3'd0;
    localparam period_t P_VIDEO_PRE   = 3'd1;
    localparam period_t P_VIDEO_GUARD = 3'd2;
    localparam period_t P_VIDEO_ACT   = 3'd3;
    localparam period_t P_DI_PRE      = 3'd4;
    localparam period_t P_DI_GUARD    = 3'd5;
    localparam period_t P_DI_ACT      = 3'd6;
endpackage

module h14tx_period_sched
    import h14tx_pkg::*;
#(
    parameter int Depth = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       de_i,
    input  logic       hsync_i,
    input  logic       vsync_i,
    input  video_t     video_i,
    input  logic       island_req,
    output logic       island_ack,
    output logic [4:0] pkt_idx,
    output period_t    period,
    output ctl_t       ctl0,
    output ctl_t       ctl1,
    output ctl_t       ctl2,
    output video_t     video_o,
    output logic       err
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PRE    = 3'd1;
    localparam logic [2:0] S_LGUARD = 3'd2;
    localparam logic [2:0] S_ACT    = 3'd3;
    localparam logic [2:0] S_TGUARD = 3'd4;

    // Bit 0 of each line is the oldest entry, i.e. the one scheduled next.
    logic [Depth-1:0] de_d;
    logic [Depth-1:0] hs_d;
    logic [Depth-1:0] vs_d;
    video_t           vid_d [Depth];

    logic [2:0] state, state_nxt;
    logic [4:0] beat, beat_nxt;
    logic [3:0] ctl_run;
    period_t    period_nxt;
    logic       vid_act, vid_guard, vid_pre, video_hit;
    logic       window_clear, island_start;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            de_d <= '0;
            hs_d <= '0;
            vs_d <= '0;
            for (int k = 0; k < Depth; k++) vid_d[k] <= '0;
        end else begin
            de_d <= {de_i, de_d[Depth-1:1]};
            hs_d <= {hsync_i, hs_d[Depth-1:1]};
            vs_d <= {vsync_i, vs_d[Depth-1:1]};
            for (int k = 0; k < Depth - 1; k++) vid_d[k] <= vid_d[k+1];
            vid_d[Depth-1] <= video_i;
        end
    end

    assign vid_act   = de_d[0];
    assign vid_guard = |de_d[2:1];
    assign vid_pre   = |de_d[10:3];
    assign video_hit = vid_act | vid_guard | vid_pre;

    // 44 island cycles + 4 control + 10 video lead-in must all be free.
    assign window_clear = ~|de_d[57:0];
    assign island_start = (state == S_IDLE) && island_req && (ctl_run >= 4'd12) && window_clear;

    always_comb begin
        period_nxt = P_CONTROL;
        if (vid_act)        period_nxt = P_VIDEO_ACT;
        else if (vid_guard) period_nxt = P_VIDEO_GUARD;
        else if (vid_pre)   period_nxt = P_VIDEO_PRE;
        else begin
            case (state)
                S_PRE:    period_nxt = P_DI_PRE;
                S_LGUARD: period_nxt = P_DI_GUARD;
                S_ACT:    period_nxt = P_DI_ACT;
                S_TGUARD: period_nxt = P_DI_GUARD;
                default:  period_nxt = P_CONTROL;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        beat_nxt  = beat;
        case (state)
            S_IDLE: begin
                if (island_start) begin
                    state_nxt = S_PRE;
                    beat_nxt  = '0;
                end
            end
            S_PRE: begin
                if (beat == 5'd7) begin
                    state_nxt = S_LGUARD;
                    beat_nxt  = '0;
                end else begin
                    beat_nxt = beat + 5'd1;
                end
            end
            S_LGUARD: begin
                if (beat == 5'd1) begin
                    state_nxt = S_ACT;
                    beat_nxt  = '0;
                end else begin
                    beat_nxt = beat + 5'd1;
                end
            end
            S_ACT: begin
                if (beat == 5'd31) begin
                    state_nxt = S_TGUARD;
                    beat_nxt  = '0;
                end else begin
                    beat_nxt = beat + 5'd1;
                end
            end
            S_TGUARD: begin
                if (beat == 5'd1) begin
                    state_nxt = S_IDLE;
                    beat_nxt  = '0;
                end else begin
                    beat_nxt = beat + 5'd1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                beat_nxt  = '0;
            end
        endcase
        // Video always wins; an island caught under it is abandoned.
        if (video_hit) begin
            state_nxt = S_IDLE;
            beat_nxt  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            beat       <= '0;
            ctl_run    <= '0;
            period     <= P_CONTROL;
            ctl0       <= '0;
            ctl1       <= '0;
            ctl2       <= '0;
            video_o    <= '0;
            island_ack <= 1'b0;
            pkt_idx    <= '0;
        end else begin
            state <= state_nxt;
            beat  <= beat_nxt;
            if (period_nxt == P_CONTROL) begin
                if (ctl_run != 4'hf) ctl_run <= ctl_run + 4'd1;
            end else begin
                ctl_run <= '0;
            end
            period     <= period_nxt;
            ctl0       <= {vs_d[0], hs_d[0]};
            ctl1       <= ((period_nxt == P_VIDEO_PRE) || (period_nxt == P_DI_PRE)) ? 2'b01 : 2'b00;
            ctl2       <= (period_nxt == P_DI_PRE) ? 2'b01 : 2'b00;
            video_o    <= vid_d[0];
            island_ack <= island_start;
            pkt_idx    <= ((state == S_ACT) && !video_hit) ? beat : 5'd0;
        end
    end

`ifdef H14TX_SCHED_CHECK_EN
    logic [3:0] pre_cnt;
    logic [1:0] guard_cnt;
    logic       va_start, pre_start, err_hit;

    assign va_start  = (period_nxt == P_VIDEO_ACT) && (period != P_VIDEO_ACT);
    assign pre_start = ((period_nxt == P_VIDEO_PRE) && (period != P_VIDEO_PRE)) ||
                       ((period_nxt == P_DI_PRE) && (period != P_DI_PRE));
    assign err_hit   = (va_start && ((guard_cnt < 2'd2) || (pre_cnt < 4'd8))) ||
                       (pre_start && (ctl_run < 4'd4));

    // pre_cnt survives the guard band so it can be judged when active video starts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_cnt   <= '0;
            guard_cnt <= '0;
            err       <= 1'b0;
        end else begin
            if (period_nxt == P_VIDEO_PRE) begin
                if (pre_cnt != 4'hf) pre_cnt <= pre_cnt + 4'd1;
            end else if (period_nxt != P_VIDEO_GUARD) begin
                pre_cnt <= '0;
            end
            if (period_nxt == P_VIDEO_GUARD) begin
                if (guard_cnt != 2'd3) guard_cnt <= guard_cnt + 2'd1;
            end else begin
                guard_cnt <= '0;
            end
            if (err_hit) err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_h14tx_period_sched.sv
// tb/tb_h14tx_period_sched.sv - self-checking bench for h14tx_period_sched
module tb_h14tx_period_sched;
    import h14tx_pkg::*;

    localparam int Depth = 64;

    logic       clk = 1'b0;
    logic       rst_n, de_i, hsync_i, vsync_i, island_req;
    video_t     video_i, video_o;
    logic       island_ack, err;
    logic [4:0] pkt_idx;
    period_t    period;
    ctl_t       ctl0, ctl1, ctl2;

    h14tx_period_sched #(.Depth(Depth)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .de_i       (de_i),
        .hsync_i    (hsync_i),
        .vsync_i    (vsync_i),
        .video_i    (video_i),
        .island_req (island_req),
        .island_ack (island_ack),
        .pkt_idx    (pkt_idx),
        .period     (period),
        .ctl0       (ctl0),
        .ctl1       (ctl1),
        .ctl2       (ctl2),
        .video_o    (video_o),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct { logic de; int len; logic req; } seg_t;
    typedef struct { period_t p; int len; } run_t;
    typedef struct {
        period_t p; ctl_t c0; ctl_t c1; ctl_t c2;
        logic [4:0] idx; logic ack; video_t v; logic e;
    } obs_t;

    int checks = 0;
    int errors = 0;

    seg_t    segs [9];
    run_t    runs [27];
    obs_t    obs [$];
    ctl_t    in_c0 [$];
    video_t  in_vid [$];
    period_t exp_p [$];
    int      exp_beat [$];
    period_t err_p [126];
    logic    err_e [126];
    ctl_t    err_c1 [126];

`ifdef H14TX_SCHED_CHECK_EN
    localparam logic ErrExp = 1'b1;
`else
    localparam logic ErrExp = 1'b0;
`endif

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic video_t pix(input int n);
        return 24'(n * 66051 + 17);
    endfunction

    initial begin
        int  cyc;
        int  n;
        int  acks;
        int  nonctl;
        bit  pending;
        ctl_t exp_c1, exp_c2;

        segs = '{'{1'b0, 200, 1'b0}, '{1'b1, 100, 1'b0}, '{1'b0, 200, 1'b1},
                 '{1'b1, 20, 1'b0},  '{1'b0, 50, 1'b1},  '{1'b1, 20, 1'b0},
                 '{1'b0, 80, 1'b0},  '{1'b1, 20, 1'b0},  '{1'b0, 100, 1'b0}};
        runs = '{'{P_CONTROL, 254}, '{P_VIDEO_PRE, 8}, '{P_VIDEO_GUARD, 2}, '{P_VIDEO_ACT, 100},
                 '{P_CONTROL, 13}, '{P_DI_PRE, 8}, '{P_DI_GUARD, 2}, '{P_DI_ACT, 32}, '{P_DI_GUARD, 2},
                 '{P_CONTROL, 133}, '{P_VIDEO_PRE, 8}, '{P_VIDEO_GUARD, 2}, '{P_VIDEO_ACT, 20},
                 '{P_CONTROL, 40}, '{P_VIDEO_PRE, 8}, '{P_VIDEO_GUARD, 2}, '{P_VIDEO_ACT, 20},
                 '{P_CONTROL, 13}, '{P_DI_PRE, 8}, '{P_DI_GUARD, 2}, '{P_DI_ACT, 32}, '{P_DI_GUARD, 2},
                 '{P_CONTROL, 13}, '{P_VIDEO_PRE, 8}, '{P_VIDEO_GUARD, 2}, '{P_VIDEO_ACT, 20},
                 '{P_CONTROL, 36}};

        rst_n = 1'b0; de_i = 1'b0; hsync_i = 1'b0; vsync_i = 1'b0;
        video_i = '0; island_req = 1'b0;
        tick();
        tick();
        check("rst_period", period, P_CONTROL);
        check("rst_ctl0", ctl0, 0);
        check("rst_ctl1", ctl1, 0);
        check("rst_ctl2", ctl2, 0);
        check("rst_video", video_o, 0);
        check("rst_ack", island_ack, 0);
        check("rst_pkt_idx", pkt_idx, 0);
        check("rst_err", err, 0);

        // Main stream: video lines, islands and a too-short blanking.
        rst_n = 1'b1;
        cyc = 0;
        pending = 1'b0;
        foreach (segs[s]) begin
            if (segs[s].req) pending = 1'b1;
            for (int k = 0; k < segs[s].len; k++) begin
                de_i       = segs[s].de;
                hsync_i    = cyc[3];
                vsync_i    = cyc[6];
                video_i    = pix(cyc);
                island_req = pending;
                in_c0.push_back({vsync_i, hsync_i});
                in_vid.push_back(video_i);
                tick();
                obs.push_back('{period, ctl0, ctl1, ctl2, pkt_idx, island_ack, video_o, err});
                if (island_ack) pending = 1'b0;
                cyc++;
            end
        end

        foreach (runs[r])
            for (int k = 0; k < runs[r].len; k++) begin
                exp_p.push_back(runs[r].p);
                exp_beat.push_back(k);
            end
        check("stream_len", obs.size(), exp_p.size());

        for (int j = 0; j < obs.size() && j < exp_p.size(); j++) begin
            check($sformatf("period[%0d]", j), obs[j].p, exp_p[j]);
            exp_c1 = (exp_p[j] == P_VIDEO_PRE || exp_p[j] == P_DI_PRE) ? 2'b01 : 2'b00;
            exp_c2 = (exp_p[j] == P_DI_PRE) ? 2'b01 : 2'b00;
            check($sformatf("ctl1[%0d]", j), obs[j].c1, exp_c1);
            check($sformatf("ctl2[%0d]", j), obs[j].c2, exp_c2);
            check($sformatf("ctl0[%0d]", j), obs[j].c0, (j >= Depth) ? in_c0[j-Depth] : 2'b00);
            check($sformatf("video[%0d]", j), obs[j].v, (j >= Depth) ? in_vid[j-Depth] : 24'd0);
            check($sformatf("ack[%0d]", j), obs[j].ack, (j == 376 || j == 666) ? 1 : 0);
            check($sformatf("err_main[%0d]", j), obs[j].e, 0);
            if (exp_p[j] == P_DI_ACT)
                check($sformatf("pkt_idx[%0d]", j), obs[j].idx, exp_beat[j]);
        end

        // Reset during island beat 10: Control next, no re-ack.
        de_i = 1'b0; hsync_i = 1'b0; vsync_i = 1'b0; video_i = '0;
        island_req = 1'b1;
        n = 0;
        while (!island_ack && n < 200) begin
            tick();
            n++;
        end
        check("mid_ack_seen", island_ack, 1);
        island_req = 1'b0;
        n = 0;
        while (!(period == P_DI_ACT && pkt_idx == 5'd10) && n < 100) begin
            tick();
            n++;
        end
        check("mid_beat10_period", period, P_DI_ACT);
        check("mid_beat10_idx", pkt_idx, 10);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_period", period, P_CONTROL);
        check("mid_rst_idx", pkt_idx, 0);
        check("mid_rst_ack", island_ack, 0);
        acks = 0;
        nonctl = 0;
        repeat (100) begin
            tick();
            acks += int'(island_ack);
            nonctl += int'(period != P_CONTROL);
        end
        check("mid_no_reack", acks, 0);
        check("mid_all_control", nonctl, 0);

        // Short (6-cycle) blanking: truncated preamble, err only with the checker built.
        for (int k = 0; k < 126; k++) begin
            de_i = (k < 20) || (k >= 26 && k < 46);
            video_i = pix(k);
            tick();
            err_p[k]  = period;
            err_e[k]  = err;
            err_c1[k] = ctl1;
        end
        check("short_va_end", err_p[83], P_VIDEO_ACT);
        for (int k = 84; k < 88; k++)
            check($sformatf("short_pre[%0d]", k), err_p[k], P_VIDEO_PRE);
        check("short_pre_ctl1", err_c1[84], 1);
        check("short_guard0", err_p[88], P_VIDEO_GUARD);
        check("short_guard1", err_p[89], P_VIDEO_GUARD);
        check("short_va_start", err_p[90], P_VIDEO_ACT);
        check("short_ctl_after", err_p[110], P_CONTROL);
        check("short_err_before", err_e[83], 0);
        check("short_err_at_pre", err_e[84], ErrExp);
        check("short_err_sticky", err_e[125], ErrExp);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/h14tx_period_sched.md
# h14tx_period_sched

Upstream stage of the per-channel encoders: takes raw video timing (de, hsync, vsync) and pixels from the timing generator and emits, per cycle, the HDMI 1.4 period (Control, VideoPreamble, VideoGuard, VideoActive, DataIslandPreamble, DataIslandGuard, DataIslandActive), per-channel control bits, and delayed, aligned pixels. A lookahead delay line lets preambles and guard bands precede DE. Data islands are inserted into blanking on request only when they fit.

## Interface
- `Depth`, 64: lookahead delay-line length in cycles; legal range 58..255.
- `clk`  in  1  pixel clock; the only clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `de_i`, `hsync_i`, `vsync_i`  in  1 each  raw timing.
- `video_i`  in  video_t  raw pixel.
- `island_req`  in  1  level; upstream has one 32-cycle packet ready.
- `island_ack`  out  1  one-cycle pulse; island accepted.
- `pkt_idx`  out  5  beat index 0..31; valid only in DataIslandActive.
- `period`  out  period_t  period for the encoders.
- `ctl0`, `ctl1`, `ctl2`  out  ctl_t each  ctl0 = {vsync, hsync}; ctl1/ctl2 = preamble codes.
- `video_o`  out  video_t  pixel aligned with `period`.
- `err`  out  1  sticky protocol error; see Configuration.

## Operation
- Delay line: `de_i`, `hsync_i`, `vsync_i` and `video_i` shift through `Depth` stages. d[0] is the oldest entry (the value now being output); d[k] is the entry output k cycles later.
- Video periods are derived from the line:
  - d[0]=1 -> VideoActive.
  - Else d[1] or d[2] = 1 -> VideoGuard.
  - Else any of d[3..10] = 1 -> VideoPreamble.
  - Otherwise Control, unless an island is in progress.
- Island FSM: IDLE -> PRE (8 cycles) -> LGUARD (2) -> ACT (32, `pkt_idx` 0..31) -> TGUARD (2) -> IDLE.
- Island start (IDLE -> PRE) requires all of:
  - `island_req`=1;
  - ctl_run >= 12;
  - d[0..57] all zero, i.e. 44 island cycles + 4 control + 10 video lead-in.
- `island_ack` pulses in the cycle PRE is entered.
- ctl_run: saturating 4-bit count of consecutive cycles with `period`=Control; cleared by any other period.
- ctl1/ctl2 values:
  - VideoPreamble: ctl1=2'b01, ctl2=2'b00.
  - DataIslandPreamble: ctl1=2'b01, ctl2=2'b01.
  - Otherwise: 2'b00.
- ctl0 always carries the delayed {vsync, hsync}.
- Because the start condition holds, the island never overlaps a video period. If both are ever computed, the video period wins and the FSM returns to IDLE.
- A request that cannot start waits; `island_req` is held by upstream until ack.

## Timing
- All outputs are registered.
- Latency from `de_i`/`video_i` to `video_o`/`period`: `Depth`+1 cycles. Throughput: one pixel per cycle, no stalls.
- `island_ack` is asserted one cycle before the first DataIslandPreamble output.
- Reset values: `period`=Control, ctl0/1/2=0, `video_o`=0, `island_ack`=0, `pkt_idx`=0, `err`=0, delay line all zero, FSM IDLE, ctl_run=0.
- Reset asserted mid-island: the next cycle outputs Control; the packet is dropped and not re-acked.
- Blanking shorter than 10 cycles: the preamble is truncated to the available cycles, and the guard still takes priority over the preamble.
- `island_req` is sampled in the same cycle as the start check; req and a qualifying window together -> start that cycle.

## Configuration
- Macro `H14TX_SCHED_CHECK_EN`.
- Defined: `err` sets and holds until reset when either:
  - VideoActive begins with fewer than 2 preceding VideoGuard cycles or 8 preceding VideoPreamble cycles; or
  - the control run before a preamble is < 4 cycles.
- Undefined: `err` is tied to 0 and the checking logic is absent; all other behaviour is identical.

## Test plan
- Reset, then de_i=1 held 100 cycles after 200 low -> Depth+1 cycles later: exactly 8 VideoPreamble with ctl1=01/ctl2=00, then 2 VideoGuard, then 100 VideoActive with `video_o` matching inputs.
- 200-cycle blanking with `island_req`=1 -> one ack pulse, then 8 DataIslandPreamble (ctl2=01), 2 DataIslandGuard, 32 DataIslandActive with `pkt_idx` 0..31, 2 DataIslandGuard; the video preamble starts at least 4 Control cycles later.
- Blanking of 50 cycles with `island_req`=1 -> no ack; req is still pending and is served in the next blanking of >= 70 cycles.
- `rst_n` low for one cycle during DataIslandActive beat 10 -> the following cycle is Control; no further ack without a new qualifying window.
- With `H14TX_SCHED_CHECK_EN`: 6-cycle blanking -> truncated preamble and `err`=1 sticky. Without the macro: same stimulus -> `err`=0.
